// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//  - state_t : FSM state encoding (IDLE / RUN / DONE)
//  - SLICE_W : width of the shared adder slice
//  - ovf_calc: two's-complement overflow from the operand and result sign bits
package nibble_serial_add_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Overflow occurs when both operands share a sign that the result does not.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_ripple_carry.sv
// ripple_carry: 4-bit ripple-carry adder shared by the serial controller.
// Ports:
//  A, B  in  4  operand slices
//  Cin   in  1  carry into bit 0
//  Sum   out 4  slice sum
//  Cout  out 1  carry out of bit 3
module ripple_carry (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [4:0] carry_s;

    // Four chained full adders.
    always_comb begin
        carry_s    = 5'b00000;
        Sum        = 4'b0000;
        carry_s[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            Sum[i]       = A[i] ^ B[i] ^ carry_s[i];
            carry_s[i+1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
        end
        Cout = carry_s[4];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit adder built from one shared 4-bit adder,
// processing one nibble per cycle (LSB first) with a registered inter-slice carry.
// Ports:
//  clk, rst              clock, synchronous active-high reset
//  in_valid/in_ready     operand handshake (a, b, cin captured on accept)
//  out_valid/out_ready   result handshake (sum, cout, ovf held while out_valid)
//  sum, cout, ovf        registered result, carry out and signed overflow
//  busy                  high while an operation is running or awaiting pickup
// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state_r;
    state_t             state_next_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               cout_r;
    logic               ovf_r;
    logic [IDX_W-1:0]   idx_r;

    logic               accept_s;
    logic               run_s;
    logic               last_slice_s;
    logic [IDX_W+1:0]   slice_lo_s;
    logic [SLICE_W-1:0] add_a_s;
    logic [SLICE_W-1:0] add_b_s;
    logic [SLICE_W-1:0] add_sum_s;
    logic               add_cout_s;

    // Operand slice selection for the shared adder.
    always_comb begin
        slice_lo_s   = {idx_r, 2'b00};
        add_a_s      = a_r[slice_lo_s +: SLICE_W];
        add_b_s      = b_r[slice_lo_s +: SLICE_W];
        accept_s     = in_valid && in_ready_r && (state_r == ST_IDLE);
        run_s        = (state_r == ST_RUN);
        last_slice_s = run_s && (idx_r == IDX_LAST);
    end

    ripple_carry u_adder (
        .A    (add_a_s),
        .B    (add_b_s),
        .Cin  (carry_r),
        .Sum  (add_sum_s),
        .Cout (add_cout_s)
    );

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_valid_r && out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Operand capture, slice counter, carry chain register and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            idx_r   <= '0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= '0;
            sum_r   <= '0;
        end else if (run_s) begin
            sum_r[slice_lo_s +: SLICE_W] <= add_sum_s;
            carry_r                      <= add_cout_s;
            if (last_slice_s) begin
                // Final slice: latch the flags and park the counter at 0 instead of wrapping.
                cout_r <= add_cout_s;
                ovf_r  <= ovf_calc(a_r[WIDTH-1], b_r[WIDTH-1], add_sum_s[SLICE_W-1]);
                idx_r  <= '0;
            end else begin
                idx_r  <= idx_r + IDX_ONE;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition of the full operands.
    task automatic model(input logic [15:0] ea, input logic [15:0] eb, input logic ec,
                         output logic [15:0] es, output logic eco, output logic eov);
        logic [16:0] t;
        t   = {1'b0, ea} + {1'b0, eb} + {16'd0, ec};
        es  = t[15:0];
        eco = t[16];
        eov = (ea[15] == eb[15]) && (es[15] != ea[15]);
    endtask

    // Offer an operation and wait (bounded) for it to be accepted.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        for (int n = 0; n < 20; n++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        check("accept", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
    endtask

    // Wait for out_valid after accept, checking latency and the result.
    task automatic wait_done(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                             input string tag);
        logic [15:0] es;
        logic        eco;
        logic        eov;
        int          lat;
        lat = 0;
        model(va, vb, vc, es, eco, eov);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int n = 1; n <= 20; n++) begin
            tick();
            out_ready = 1'($urandom);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        out_ready = 1'b0;
        check({tag, "_latency"}, lat, 32'd4);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, eco});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eov});
        check({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    endtask

    // Stall in DONE, then hand the result off.
    task automatic finish_op(input int stall, input string tag);
        logic [15:0] held;
        held = sum;
        out_ready = 1'b0;
        for (int n = 0; n < stall; n++) begin
            tick();
            if (sum !== held || out_valid !== 1'b1) begin
                check({tag, "_stall_sum"}, {16'd0, sum}, {16'd0, held});
                check({tag, "_stall_vld"}, {31'd0, out_valid}, 32'd1);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin : stim
        logic [15:0] held;
        rst = 1'b1;
        in_valid = 1'b0;
        a = 16'd0;
        b = 16'd0;
        cin = 1'b0;
        out_ready = 1'b0;

        // 1. Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);

        // 2. Basic add
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(16'h1234, 16'h4321, 1'b0, "t2");
        check("t2_exact", {16'd0, sum}, 32'h5555);
        finish_op(0, "t2");

        // 3. Full carry ripple
        start_op(16'hFFFF, 16'h0000, 1'b1);
        wait_done(16'hFFFF, 16'h0000, 1'b1, "t3");
        check("t3_exact", {15'd0, cout, sum}, 32'h10000);
        finish_op(1, "t3");

        // 4. Signed overflow both directions
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(16'h7FFF, 16'h0001, 1'b0, "t4a");
        check("t4a_exact", {14'd0, ovf, cout, sum}, 32'h28000);
        finish_op(0, "t4a");
        start_op(16'h8000, 16'h8000, 1'b0);
        wait_done(16'h8000, 16'h8000, 1'b0, "t4b");
        check("t4b_exact", {14'd0, ovf, cout, sum}, 32'h30000);
        finish_op(0, "t4b");

        // 5. Back-pressure with a pending request in DONE
        start_op(16'h0102, 16'h0304, 1'b0);
        wait_done(16'h0102, 16'h0304, 1'b0, "t5");
        held = sum;
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            a = 16'($urandom);
            b = 16'h1111;
            cin = 1'b0;
            tick();
            check("t5_stable", {16'd0, sum}, {16'd0, held});
            check("t5_inrdy", {31'd0, in_ready}, 32'd0);
            check("t5_vld", {31'd0, out_valid}, 32'd1);
        end
        a = 16'h2222;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t5_idle", {29'd0, out_valid, in_ready, busy}, 32'd2);
        tick();
        in_valid = 1'b0;
        check("t5_accept", {30'd0, busy, in_ready}, 32'd2);
        wait_done(16'h2222, 16'h1111, 1'b0, "t5n");
        finish_op(0, "t5n");

        // 6. Reset mid-operation
        start_op(16'hABCD, 16'h1234, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_abort", {29'd0, out_valid, in_ready, busy}, 32'd2);
        held = 16'd0;
        for (int n = 0; n < 6; n++) begin
            tick();
            held = held | {15'd0, out_valid};
        end
        check("t6_no_valid", {16'd0, held}, 32'd0);
        start_op(16'h00FF, 16'h0001, 1'b0);
        wait_done(16'h00FF, 16'h0001, 1'b0, "t6b");
        check("t6b_exact", {16'd0, sum}, 32'h0100);
        finish_op(0, "t6b");

        // Random scoreboard
        for (int k = 0; k < 1000; k++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            start_op(ra, rb, rc);
            wait_done(ra, rb, rc, "rnd");
            finish_op(int'($urandom_range(0, 3)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
